// File: rtl/fan_pkg.sv
// fan_pkg: shared state encoding, off-timer presets and default level duties for fan_scheduler
package fan_pkg;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DOWN} fan_state_e;

  localparam logic [8:0] TMR_P1 = 9'd60;
  localparam logic [8:0] TMR_P2 = 9'd180;
  localparam logic [8:0] TMR_P3 = 9'd300;

  localparam logic [7:0] LVL1_DUTY_DEF = 8'd85;
  localparam logic [7:0] LVL2_DUTY_DEF = 8'd170;
  localparam logic [7:0] LVL3_DUTY_DEF = 8'd255;

  // Next preset above the current remaining time; a partly elapsed timer moves up to the next preset.
  function automatic logic [8:0] next_preset(input logic [8:0] r);
    return r == 9'd0 ? TMR_P1 : r <= TMR_P1 ? TMR_P2 : r <= TMR_P2 ? TMR_P3 : 9'd0;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running prescaler emitting a one-cycle tick every DIV cycles, restartable by a sync clear
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int W = DIV > 1 ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = cnt == W'(DIV - 1);

  // Count up, wrapping on tick; clear restarts the period from zero.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;

endmodule

// File: rtl/fan_scheduler.sv
// fan_scheduler: power-level / ramped duty / oscillation / off-timer controller; off-timer built only with FAN_SCHEDULER_TIMER_EN
module fan_scheduler
  import fan_pkg::*;
#(
  parameter int         RAMP_DIV   = 100_000,
  parameter int         TIMER_UNIT = 100_000_000,
  parameter logic [7:0] LVL1_DUTY  = LVL1_DUTY_DEF,
  parameter logic [7:0] LVL2_DUTY  = LVL2_DUTY_DEF,
  parameter logic [7:0] LVL3_DUTY  = LVL3_DUTY_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_power,
  input  logic       btn_timer,
  input  logic       btn_spin,
  output logic [7:0] duty,
  output logic [1:0] level,
  output logic       spin_en,
  output logic [8:0] timer_remain
);

  fan_state_e state, state_nxt;
  logic [1:0] level_nxt;
  logic [7:0] target, target_nxt, step, duty_nxt;
  logic       lvl_chg, ramping, ramp_tick, ramp_clr, ramp_step, expire;

  function automatic logic [7:0] lvl_duty(input logic [1:0] l);
    return l == 2'd0 ? 8'd0 : l == 2'd1 ? LVL1_DUTY : l == 2'd2 ? LVL2_DUTY : LVL3_DUTY;
  endfunction

  // Timer expiry overrides a coincident power press; 3 wraps to 0 naturally in two bits.
  assign level_nxt  = expire ? 2'd0 : level + {1'b0, btn_power};
  assign lvl_chg    = level_nxt != level;
  assign target     = lvl_duty(level);
  assign target_nxt = lvl_duty(level_nxt);
  assign ramping    = state == RAMP_UP || state == RAMP_DOWN;
  assign step       = state == RAMP_UP ? (duty == 8'hFF ? duty : duty + 8'd1)
                                       : (duty == 8'h00 ? duty : duty - 8'd1);

  tick_gen #(.DIV(RAMP_DIV)) u_ramp_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ramp_clr),
    .tick    (ramp_tick)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;

  // Next state: a level change picks the ramp direction from the current duty, a finished ramp settles.
  always_comb begin
    state_nxt = state;
    if (lvl_chg)
      state_nxt = target_nxt > duty ? RAMP_UP : target_nxt < duty ? RAMP_DOWN : state;
    else if (ramping && (duty == target || (ramp_step && step == target)))
      state_nxt = target == 8'd0 ? IDLE : RUN;
  end

  // FSM outputs: ramp prescaler held in reset outside ramps and restarted on a level change.
  always_comb begin
    ramp_clr  = lvl_chg || !ramping;
    ramp_step = ramping && ramp_tick && !lvl_chg;
    duty_nxt  = ramp_step ? step : duty;
  end

  // Datapath registers: duty, level and oscillation enable (cleared whenever the fan is off).
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      duty    <= 8'd0;
      level   <= 2'd0;
      spin_en <= 1'b0;
    end else begin
      duty    <= duty_nxt;
      level   <= level_nxt;
      spin_en <= level_nxt != 2'd0 && (spin_en ^ (btn_spin && level != 2'd0));
    end

`ifdef FAN_SCHEDULER_TIMER_EN

  logic tmr_tick, tmr_load;

  // A timer press is judged against the level after any coincident power press.
  assign tmr_load = btn_timer && level_nxt != 2'd0;
  assign expire   = tmr_tick && timer_remain == 9'd1;

  tick_gen #(.DIV(TIMER_UNIT)) u_tmr_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_remain == 9'd0 || level_nxt == 2'd0 || tmr_load),
    .tick    (tmr_tick)
  );

  // Off-timer: cleared when the fan goes off, reloaded by the button, otherwise counts down per unit.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) timer_remain <= 9'd0;
    else if (level_nxt == 2'd0) timer_remain <= 9'd0;
    else if (tmr_load) timer_remain <= next_preset(timer_remain);
    else if (tmr_tick && timer_remain != 9'd0) timer_remain <= timer_remain - 9'd1;

`else

  logic unused_timer;

  assign unused_timer = btn_timer ^ (TIMER_UNIT == 0);
  assign expire       = 1'b0;
  assign timer_remain = 9'd0;

`endif

endmodule

// File: doc/fan_scheduler.md
FAN_SCHEDULER -- requirements
Module: fan_scheduler

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 100_000, clock cycles per duty ramp step.
REQ-002 SHALL have parameter TIMER_UNIT, default 100_000_000, clock cycles per off-timer unit (1 s at 100 MHz).
REQ-003 SHALL have parameters LVL1_DUTY/LVL2_DUTY/LVL3_DUTY, defaults 85/170/255, 8-bit target duty per power level.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port btn_power  input  1  one-cycle pulse, advances power level.
REQ-007 SHALL have port btn_timer  input  1  one-cycle pulse, advances off-timer preset.
REQ-008 SHALL have port btn_spin  input  1  one-cycle pulse, toggles head-oscillation enable.
REQ-009 SHALL have port duty  output  8  motor PWM duty, also the power indication for the oscillation block.
REQ-010 SHALL have port level  output  2  current power level 0..3.
REQ-011 SHALL have port spin_en  output  1  oscillation enable.
REQ-012 SHALL have port timer_remain  output  9  remaining off-timer units, 0 = timer inactive.

Function
REQ-013 SHALL implement states IDLE, RAMP_UP, RUN, RAMP_DOWN; target = 0 for level 0, else LVLn_DUTY.
REQ-014 btn_power SHALL cycle level 0->1->2->3->0, applied the cycle after the pulse.
REQ-015 On level change: target > duty -> RAMP_UP; target < duty -> RAMP_DOWN; equal -> unchanged state.
REQ-016 In RAMP_UP/RAMP_DOWN, duty SHALL move 1 LSB toward target per ramp tick (every RAMP_DIV cycles); on reaching target -> RUN, or IDLE if target is 0.
REQ-017 Ramp tick counter SHALL restart at 0 on every level change; direction reversal mid-ramp SHALL continue from current duty without jump.
REQ-018 btn_timer SHALL cycle timer_remain presets 0->60->180->300->0, only when level != 0; ignored when level = 0.
REQ-019 Nonzero timer_remain SHALL decrement once per TIMER_UNIT cycles; transition 1->0 SHALL force level 0 (ramp down).
REQ-020 Level reaching 0 by any means SHALL clear timer_remain and its prescaler.
REQ-021 btn_spin SHALL toggle spin_en only while level != 0; spin_en SHALL be forced 0 whenever level = 0.
REQ-022 Simultaneous btn_power and timer expiry: expiry wins, level = 0; simultaneous btn_power and btn_timer: both applied, btn_timer evaluated against the new level.
REQ-023 duty SHALL never exceed 255 nor underflow below 0; ramp arithmetic SHALL saturate.

Reset
REQ-024 reset_n low SHALL asynchronously set duty 0, level 0, spin_en 0, timer_remain 0, state IDLE, all prescalers 0.
REQ-025 Reset asserted mid-ramp SHALL drop duty to 0 immediately, with no ramp-down.

Configuration
REQ-026 With FAN_SCHEDULER_TIMER_EN defined, off-timer per REQ-018..020 SHALL be present.
REQ-027 Without FAN_SCHEDULER_TIMER_EN, btn_timer SHALL be ignored, timer_remain tied 0, no timer prescaler synthesized.

Structure
REQ-028 Shared package fan_pkg SHALL hold the state enum, timer preset constants (60/180/300) and default level duties.
REQ-029 Prescaler SHALL be sub-module tick_gen (parameter DIV, sync clear input, one-cycle tick output), instantiated for ramp and timer.

Verification (RAMP_DIV=4, TIMER_UNIT=10)
REQ-030 btn_power once from reset -> level 1, duty 0->85 in steps every 4 cycles, RUN after 340 cycles.
REQ-031 At level 3 duty 255, btn_power -> level 0, RAMP_DOWN, duty reaches 0 after 1020 cycles, IDLE, spin_en 0.
REQ-032 Level 1 running, btn_timer once -> timer_remain 60, decrements every 10 cycles, at 0 level forced 0 and ramp down.
REQ-033 btn_timer and btn_spin pulsed in IDLE -> timer_remain 0, spin_en 0, no change.
REQ-034 reset_n low during RAMP_UP at duty 40 -> duty 0, state IDLE same cycle, all outputs at reset values.
REQ-035 btn_power coincident with final timer decrement -> level 0, timer_remain 0.
